i2s_clkws_cfg_ctrl: RTL and testbench

Sequences every configuration change of the I2S clock/WS generator so that the clock-mux selects and divider values never change while a clock is running. Requests come from the uDMA I2S register file as a single-cycle request carrying the full target configuration. The block drives all static config inputs of the clock/WS generator: the enables, clock selects, dividers and the PDM enable. Each update runs as quiesce -> switch -> settle -> enable, followed by a done pulse.

---
 rtl/i2s_clkws_cfg_pkg.sv | 37 +++
 rtl/i2s_cfg_wait_cnt.sv | 26 ++
 rtl/i2s_clkws_cfg_ctrl.sv | 176 +++++++++++++++++
 tb/tb_i2s_clkws_cfg_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_clkws_cfg_pkg.sv
// Shared types and defaults for the I2S clock/WS generator configuration sequencer.
package i2s_clkws_cfg_pkg;

    localparam int DRAIN_MIN_DEF     = 8;
    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWITCH,
        ST_SETTLE,
        ST_ENABLE
    } state_e;

    typedef struct packed {
        logic        master_en;
        logic        slave_en;
        logic        pdm_en;
        logic        sel_master_num;
        logic        sel_master_ext;
        logic        sel_slave_num;
        logic        sel_slave_ext;
        logic [15:0] div_0;
        logic [15:0] div_1;
    } cfg_t;

    // Drain time covers two periods of the slowest divided clock plus the enable-sync latency.
    function automatic int unsigned drain_cycles(input logic [15:0] d0,
                                                 input logic [15:0] d1,
                                                 input int unsigned drain_min);
        logic [15:0] mx;
        mx = (d0 > d1) ? d0 : d1;
        return drain_min + 32'd4 * (32'(mx) + 32'd1);
    endfunction

endpackage

// File: rtl/i2s_cfg_wait_cnt.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module i2s_cfg_wait_cnt #(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/i2s_clkws_cfg_ctrl.sv
// Sequences clock/WS generator reconfiguration: quiesce enables, switch selects/dividers,
// let the muxes settle, then re-enable and pulse done.
module i2s_clkws_cfg_ctrl
    import i2s_clkws_cfg_pkg::*;
#(
    parameter int DRAIN_MIN     = DRAIN_MIN_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cfg_req_i,
    input  logic        cfg_master_en_i,
    input  logic        cfg_slave_en_i,
    input  logic        cfg_pdm_en_i,
    input  logic        cfg_sel_master_num_i,
    input  logic        cfg_sel_master_ext_i,
    input  logic        cfg_sel_slave_num_i,
    input  logic        cfg_sel_slave_ext_i,
    input  logic [15:0] cfg_div_0_i,
    input  logic [15:0] cfg_div_1_i,
    output logic        master_en_o,
    output logic        slave_en_o,
    output logic        pdm_en_o,
    output logic        sel_master_num_o,
    output logic        sel_master_ext_o,
    output logic        sel_slave_num_o,
    output logic        sel_slave_ext_o,
    output logic [15:0] div_0_o,
    output logic [15:0] div_1_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        ovr_o
);

    state_e           r_state, w_state_next;
    cfg_t             r_shadow, r_out, w_out_next, w_target;
    logic             r_busy, r_done, r_ovr;
    logic             w_accept, w_any_en, w_same, w_cnt_load, w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_val;
    logic [35:0]      w_seldiv_cur, w_seldiv_next, w_seldiv_shadow;

    assign w_target = '{
        master_en:      cfg_master_en_i,
        slave_en:       cfg_slave_en_i,
        pdm_en:         cfg_pdm_en_i,
        sel_master_num: cfg_sel_master_num_i,
        sel_master_ext: cfg_sel_master_ext_i,
        sel_slave_num:  cfg_sel_slave_num_i,
        sel_slave_ext:  cfg_sel_slave_ext_i,
        div_0:          cfg_div_0_i,
        div_1:          cfg_div_1_i
    };

    assign w_any_en        = r_out.master_en | r_out.slave_en | r_out.pdm_en;
    assign w_seldiv_cur    = {r_out.sel_master_num, r_out.sel_master_ext, r_out.sel_slave_num,
                              r_out.sel_slave_ext, r_out.div_0, r_out.div_1};
    assign w_seldiv_next   = {w_out_next.sel_master_num, w_out_next.sel_master_ext,
                              w_out_next.sel_slave_num, w_out_next.sel_slave_ext,
                              w_out_next.div_0, w_out_next.div_1};
    assign w_seldiv_shadow = {r_shadow.sel_master_num, r_shadow.sel_master_ext,
                              r_shadow.sel_slave_num, r_shadow.sel_slave_ext,
                              r_shadow.div_0, r_shadow.div_1};
    assign w_same          = (w_seldiv_shadow == w_seldiv_cur);

    always_comb begin
        w_state_next = r_state;
        w_out_next   = r_out;
        w_accept     = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_val    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (cfg_req_i) begin
                    w_accept = 1'b1;
                    if (w_any_en) begin
                        // Loaded with N-1 so DRAIN lasts exactly N cycles.
                        w_state_next = ST_DRAIN;
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = CNT_W'(drain_cycles(r_out.div_0, r_out.div_1,
                                                           DRAIN_MIN) - 32'd1);
                    end else begin
                        w_state_next = ST_SWITCH;
                    end
                end
            end
            ST_DRAIN: begin
                w_out_next.master_en = 1'b0;
                w_out_next.slave_en  = 1'b0;
                w_out_next.pdm_en    = 1'b0;
                if (w_cnt_zero) begin
                    w_state_next = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_out_next.sel_master_num = r_shadow.sel_master_num;
                w_out_next.sel_master_ext = r_shadow.sel_master_ext;
                w_out_next.sel_slave_num  = r_shadow.sel_slave_num;
                w_out_next.sel_slave_ext  = r_shadow.sel_slave_ext;
                w_out_next.div_0          = r_shadow.div_0;
                w_out_next.div_1          = r_shadow.div_1;
                if (w_same) begin
                    w_state_next = ST_ENABLE;
                end else begin
                    w_state_next = ST_SETTLE;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                w_out_next.master_en = r_shadow.master_en;
                w_out_next.slave_en  = r_shadow.slave_en;
                w_out_next.pdm_en    = r_shadow.pdm_en;
                w_state_next         = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state  <= ST_IDLE;
            r_out    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_ENABLE);
            if (w_accept) begin
                r_shadow <= w_target;
                r_ovr    <= 1'b0;
            end else if (cfg_req_i && r_busy) begin
                r_ovr <= 1'b1;
            end
        end
    end

    i2s_cfg_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (w_cnt_load),
        .load_val_i (w_cnt_val),
        .zero_o     (w_cnt_zero)
    );

    a_seldiv_stable_while_enabled: assert property (
        @(posedge clk_i) disable iff (!rstn_i) w_any_en |-> (w_seldiv_next == w_seldiv_cur)
    );

    assign master_en_o      = r_out.master_en;
    assign slave_en_o       = r_out.slave_en;
    assign pdm_en_o         = r_out.pdm_en;
    assign sel_master_num_o = r_out.sel_master_num;
    assign sel_master_ext_o = r_out.sel_master_ext;
    assign sel_slave_num_o  = r_out.sel_slave_num;
    assign sel_slave_ext_o  = r_out.sel_slave_ext;
    assign div_0_o          = r_out.div_0;
    assign div_1_o          = r_out.div_1;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign ovr_o            = r_ovr;

endmodule

// File: tb/tb_i2s_clkws_cfg_ctrl.sv
// Scoreboard bench: stimulus predicts done cycle and final outputs; a monitor checks them.
module tb_i2s_clkws_cfg_ctrl;
    import i2s_clkws_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_req = 1'b0;
    cfg_t        drv = '0;
    logic        master_en, slave_en, pdm_en;
    logic        sel_mn, sel_me, sel_sn, sel_se;
    logic [15:0] div_0, div_1;
    logic        busy, done, ovr;

    always #5 clk = ~clk;

    i2s_clkws_cfg_ctrl dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .cfg_req_i            (cfg_req),
        .cfg_master_en_i      (drv.master_en),
        .cfg_slave_en_i       (drv.slave_en),
        .cfg_pdm_en_i         (drv.pdm_en),
        .cfg_sel_master_num_i (drv.sel_master_num),
        .cfg_sel_master_ext_i (drv.sel_master_ext),
        .cfg_sel_slave_num_i  (drv.sel_slave_num),
        .cfg_sel_slave_ext_i  (drv.sel_slave_ext),
        .cfg_div_0_i          (drv.div_0),
        .cfg_div_1_i          (drv.div_1),
        .master_en_o          (master_en),
        .slave_en_o           (slave_en),
        .pdm_en_o             (pdm_en),
        .sel_master_num_o     (sel_mn),
        .sel_master_ext_o     (sel_me),
        .sel_slave_num_o      (sel_sn),
        .sel_slave_ext_o      (sel_se),
        .div_0_o              (div_0),
        .div_1_o              (div_1),
        .busy_o               (busy),
        .done_o               (done),
        .ovr_o                (ovr)
    );

    typedef struct {
        int   done_cyc;
        cfg_t cfg;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   m_last_done = -1;
    bit   m_ovr = 1'b0;
    cfg_t m_cur = '0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cfg_t dut_cfg();
        cfg_t c;
        c = '{master_en: master_en, slave_en: slave_en, pdm_en: pdm_en,
              sel_master_num: sel_mn, sel_master_ext: sel_me,
              sel_slave_num: sel_sn, sel_slave_ext: sel_se,
              div_0: div_0, div_1: div_1};
        return c;
    endfunction

    // Reference model: drain of two slow-clock periods, settle only when muxes/dividers move.
    function automatic int drain_len(input cfg_t c);
        int mx;
        mx = (int'(c.div_0) > int'(c.div_1)) ? int'(c.div_0) : int'(c.div_1);
        return 8 + 4 * (mx + 1);
    endfunction

    function automatic bit seldiv_differs(input cfg_t a, input cfg_t b);
        return (a.sel_master_num != b.sel_master_num) || (a.sel_master_ext != b.sel_master_ext) ||
               (a.sel_slave_num != b.sel_slave_num) || (a.sel_slave_ext != b.sel_slave_ext) ||
               (a.div_0 != b.div_0) || (a.div_1 != b.div_1);
    endfunction

    // Monitor: sampled #1 after each rising edge; cyc is the index of the cycle being observed.
    cfg_t prev = '0;
    bit   prev_en = 1'b0;
    bit   final_pending = 1'b0;
    cfg_t final_cfg = '0;
    always @(posedge clk) begin
        cfg_t act;
        exp_t e;
        #1;
        cyc = cyc + 1;
        act = dut_cfg();
        if (rstn) begin
            if (prev_en) begin
                chk("seldiv_stable_while_en",
                    {act.sel_master_num, act.sel_master_ext, act.sel_slave_num, act.sel_slave_ext,
                     act.div_0, act.div_1},
                    {prev.sel_master_num, prev.sel_master_ext, prev.sel_slave_num,
                     prev.sel_slave_ext, prev.div_0, prev.div_1});
            end
            if (final_pending) begin
                chk("final_cfg", act, final_cfg);
                chk("busy_after_done", busy, 0);
                final_pending = 1'b0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    final_cfg = e.cfg;
                    final_pending = 1'b1;
                end
            end
        end else begin
            final_pending = 1'b0;
        end
        prev = act;
        prev_en = act.master_en | act.slave_en | act.pdm_en;
    end

    task automatic send(input cfg_t t, output int req_cyc);
        int lat;
        @(negedge clk);
        req_cyc = cyc;
        drv = t;
        cfg_req = 1'b1;
        if (cyc > m_last_done) begin
            lat = 2 + ((m_cur.master_en | m_cur.slave_en | m_cur.pdm_en) ? drain_len(m_cur) : 0)
                    + (seldiv_differs(t, m_cur) ? 4 : 0);
            m_last_done = cyc + lat;
            q.push_back('{done_cyc: cyc + lat, cfg: t});
            m_cur = t;
            m_ovr = 1'b0;
            $display("req cyc=%0d accepted cfg=0x%0h expect done=%0d", cyc, t, cyc + lat);
        end else begin
            m_ovr = 1'b1;
            $display("req cyc=%0d dropped (busy) cfg=0x%0h", cyc, t);
        end
        @(negedge clk);
        cfg_req = 1'b0;
        chk("ovr", ovr, m_ovr);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc <= m_last_done + 1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("wait_idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("wait_until_timeout", 1, 0);
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t r;
        r = '0;
        r.master_en      = 1'($urandom_range(0, 1));
        r.slave_en       = 1'($urandom_range(0, 1));
        r.pdm_en         = 1'($urandom_range(0, 1));
        r.sel_master_num = 1'($urandom_range(0, 1));
        r.sel_master_ext = 1'($urandom_range(0, 1));
        r.sel_slave_num  = 1'($urandom_range(0, 1));
        r.sel_slave_ext  = 1'($urandom_range(0, 1));
        r.div_0          = 16'($urandom_range(0, 40));
        r.div_1          = 16'($urandom_range(0, 40));
        return r;
    endfunction

    initial begin
        cfg_t a, b;
        int   rc, dummy;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {dut_cfg(), busy, done, ovr}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Enables off, no drain; select/divider change -> settle, enable at N+7.
        a = '0; a.master_en = 1'b1; a.sel_master_num = 1'b1; a.div_1 = 16'd3;
        send(a, rc);
        wait_until(rc + 2);
        chk("seldiv_at_n2", {sel_mn, div_1}, {1'b1, 16'd3});
        chk("en_still_off_n2", master_en, 0);
        wait_until(rc + 7);
        chk("master_en_at_n7", master_en, 1);
        wait_idle();

        // Running at div 10/2, then move sel_master_ext -> 52-cycle drain.
        a = '0; a.master_en = 1'b1; a.sel_master_num = 1'b1; a.div_0 = 16'd10; a.div_1 = 16'd2;
        send(a, rc);
        wait_idle();
        b = a; b.sel_master_ext = 1'b1;
        send(b, rc);
        chk("en_held_n1", master_en, 1);
        wait_until(rc + 2);
        chk("en_dropped_n2", master_en, 0);
        wait_until(rc + 53);
        chk("sel_old_at_n53", sel_me, 0);
        wait_until(rc + 54);
        chk("sel_new_at_n54", sel_me, 1);
        wait_idle();

        // Identical request while enabled: drain, settle skipped.
        send(b, rc);
        wait_idle();

        // Second request during drain is dropped and flags overrun.
        a = b; a.div_0 = 16'd4; a.slave_en = 1'b1;
        send(a, rc);
        send(b, dummy);
        wait_idle();
        chk("ovr_sticky", ovr, 1);
        send(b, rc);
        wait_idle();

        // Reset in the middle of settle.
        a = b; a.sel_slave_num = 1'b1;
        send(a, rc);
        wait_until(rc + 1 + drain_len(b) + 2);
        rstn = 1'b0;
        q.delete();
        m_cur = '0; m_last_done = -1; m_ovr = 1'b0;
        @(negedge clk);
        chk("reset_mid_settle", {dut_cfg(), busy, done, ovr}, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Stop: all enables 0 with new dividers while running.
        a = '0; a.pdm_en = 1'b1; a.div_0 = 16'd5;
        send(a, rc);
        wait_idle();
        b = '0; b.div_0 = 16'd7; b.div_1 = 16'd1; b.sel_slave_ext = 1'b1;
        send(b, rc);
        wait_idle();

        // Randomized traffic, sometimes overlapping to provoke drops.
        for (int i = 0; i < 40; i++) begin
            send(rand_cfg(), rc);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        wait_idle();
        repeat (4) @(negedge clk);
        if (q.size() != 0) chk("pending_transactions", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
